// File: rtl/cmd_responder.sv
// Serial command responder: receives 3-byte 8N1 command frames (cmd, data_hi, data_lo)
// and transmits single 8N1 response bytes, with independent RX and TX engines.
`timescale 1ns/1ps
module cmd_responder #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        snd_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);
  localparam logic [16:0] TO_LAST   = 17'(32 * BAUD_DIV - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  logic        rx_sync1_q, rx_sync1_d;
  logic        rx_sync2_q, rx_sync2_d;
  logic        rx_prev_q, rx_prev_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [16:0] to_cnt_q, to_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        frm_err_q, frm_err_d;
  logic        rdy_set_s, rdy_clr_s;

  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic        resp_sent_q, resp_sent_d;

  // Receive path: synchronizer, byte FSM, frame assembly and inter-byte timeout
  always_comb begin
    rx_sync1_d = RX;
    rx_sync2_d = rx_sync1_q;
    rx_prev_d  = rx_sync2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 12'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_cnt_d = byte_cnt_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    to_cnt_d   = 17'd0;
    cmd_d      = cmd_q;
    data_d     = data_q;
    frm_err_d  = 1'b0;
    rdy_set_s  = 1'b0;
    rdy_clr_s  = clr_cmd_rdy;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 12'd0;
        rx_bit_d = 3'd0;
        // A partial frame is dropped if the next start bit is too late
        if (byte_cnt_q != 2'd0) begin
          if (to_cnt_q == TO_LAST) begin
            byte_cnt_d = 2'd0;
            to_cnt_d   = 17'd0;
          end else begin
            to_cnt_d = to_cnt_q + 17'd1;
          end
        end else begin
          to_cnt_d = 17'd0;
        end
        if (!rx_sync2_q && rx_prev_q) begin
          rx_state_d = RX_START;
          to_cnt_d   = 17'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = 12'd0;
          if (!rx_sync2_q) begin
            rx_state_d = RX_DATA;
            rdy_clr_s  = clr_cmd_rdy || (byte_cnt_q == 2'd0);
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 12'd0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
            rx_bit_d   = 3'd0;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 12'd0;
          rx_state_d = RX_IDLE;
          if (rx_sync2_q) begin
            case (byte_cnt_q)
              2'd0: begin
                byte0_d    = rx_shift_q;
                byte_cnt_d = 2'd1;
              end
              2'd1: begin
                byte1_d    = rx_shift_q;
                byte_cnt_d = 2'd2;
              end
              default: begin
                cmd_d      = byte0_q;
                data_d     = {byte1_q, rx_shift_q};
                rdy_set_s  = 1'b1;
                byte_cnt_d = 2'd0;
              end
            endcase
          end else begin
            frm_err_d  = 1'b1;
            byte_cnt_d = 2'd0;
          end
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = 12'd0;
      end
    endcase

    // Completion takes priority over any clear in the same cycle
    if (rdy_set_s) begin
      cmd_rdy_d = 1'b1;
    end else if (rdy_clr_s) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  // Transmit path: start, eight data bits LSB first, stop, then a one-cycle done pulse
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 12'd1;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = 12'd0;
        tx_bit_d  = 3'd0;
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (snd_resp) begin
          tx_shift_d = resp;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = 12'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = 12'd0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_bit_d   = 3'd0;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = 12'd0;
          tx_state_d  = TX_IDLE;
          tx_busy_d   = 1'b0;
          resp_sent_d = 1'b1;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = 12'd0;
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync1_q  <= 1'b1;
      rx_sync2_q  <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 12'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      byte_cnt_q  <= 2'd0;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      to_cnt_q    <= 17'd0;
      cmd_q       <= 8'h00;
      data_q      <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 12'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_sync1_q  <= rx_sync1_d;
      rx_sync2_q  <= rx_sync2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      byte_cnt_q  <= byte_cnt_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      to_cnt_q    <= to_cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frm_err_q   <= frm_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frm_err   = frm_err_q;
  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Self-checking bench for cmd_responder at BAUD_DIV = 16: directed frame table,
// hand-written corner sequences, and randomized full-duplex traffic against a byte-queue model.
`timescale 1ns/1ps
module tb_cmd_responder;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        snd_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, resp_sent, tx_busy, frm_err;
  logic [7:0]  cmd;
  logic [15:0] data;

  cmd_responder #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .snd_resp(snd_resp), .resp(resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int frm_cnt = 0;
  int rs_cnt = 0;
  int rdy_rise = 0;
  logic rdy_prev = 1'b0;
  logic rdy_at_stop = 1'b0;

  // Pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (frm_err) frm_cnt++;
    if (resp_sent) rs_cnt++;
    if (cmd_rdy && !rdy_prev) rdy_rise++;
    rdy_prev = cmd_rdy;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the first nbits of an 8N1 frame (start, 8 data LSB first, stop); line left idle high
  task automatic send_byte(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      RX = fr[j];
      if (j == 9) rdy_at_stop = cmd_rdy;
      tick(BD);
    end
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1, 10);
    tick(4);
    send_byte(b1, 1'b1, 10);
    tick(4);
    send_byte(b2, 1'b1, 10);
  endtask

  // Issue one response and check the whole TX waveform and completion timing
  task automatic tx_check(input logic [7:0] r, input bit with_ignore);
    logic [9:0] got;
    logic       busy1;
    int sent_at, fall_at, pulses;
    got = 10'h000; busy1 = 1'b0;
    sent_at = -1; fall_at = -1; pulses = 0;
    resp = r;
    snd_resp = 1'b1;
    tick(1);
    snd_resp = 1'b0;
    resp = 8'($urandom);
    for (int n = 1; n <= 170; n++) begin
      if (n == 1) busy1 = tx_busy;
      if ((n % BD) == (BD / 2) && n <= 10 * BD) got[(n - BD / 2) / BD] = TX;
      if (resp_sent) begin
        pulses++;
        if (sent_at < 0) sent_at = n;
      end
      if (!tx_busy && fall_at < 0) fall_at = n;
      if (with_ignore && n == 50) begin
        snd_resp = 1'b1;
        resp = ~r;
      end
      if (with_ignore && n == 51) snd_resp = 1'b0;
      tick(1);
    end
    chk("tx_waveform", 32'(got), 32'({1'b1, r, 1'b0}));
    chk("tx_busy_rise", 32'(busy1), 32'd1);
    chk("resp_sent_cycle", 32'(sent_at), 32'(10 * BD + 1));
    chk("tx_busy_fall", 32'(fall_at), 32'(10 * BD + 1));
    chk("resp_sent_pulses", 32'(pulses), 32'd1);
  endtask

  typedef struct {
    int          pre;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
    int          exp_frm;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]  pc;
    logic [15:0] pd;
    logic        saw_high;
    int          f0, rs0, r0;

    vecs[0] = '{0, 8'h01, 8'h01, 8'h01, 8'h01, 16'h0101, 0};
    vecs[1] = '{0, 8'h02, 8'hA5, 8'h3C, 8'h02, 16'hA53C, 0};
    vecs[2] = '{1, 8'h05, 8'h00, 8'h10, 8'h05, 16'h0010, 1};
    vecs[3] = '{2, 8'h06, 8'h12, 8'h34, 8'h06, 16'h1234, 0};
    vecs[4] = '{0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 0};

    tick(3);
    chk("rst_TX", 32'(TX), 32'd1);
    chk("rst_cmd", 32'(cmd), 32'h00);
    chk("rst_data", 32'(data), 32'h0000);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp_sent", 32'(resp_sent), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_frm_err", 32'(frm_err), 32'd0);
    rst_n = 1'b1;
    tick(5);

    pc = 8'h00;
    pd = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      f0 = frm_cnt;
      if (vecs[i].pre == 1) begin
        send_byte(8'h07, 1'b1, 10);
        tick(4);
        send_byte(8'h08, 1'b0, 10);
        tick(4);
      end else if (vecs[i].pre == 2) begin
        send_byte(8'h09, 1'b1, 10);
        tick(4);
        send_byte(8'h0A, 1'b1, 10);
        tick(600);
      end
      if (vecs[i].pre != 0) begin
        chk("partial_keeps_cmd", 32'(cmd), 32'(pc));
        chk("partial_keeps_data", 32'(data), 32'(pd));
        chk("partial_rdy_cleared", 32'(cmd_rdy), 32'd0);
      end
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      chk("vec_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
      chk("vec_data", 32'(data), 32'(vecs[i].exp_data));
      chk("vec_rdy_low_before_stop", 32'(rdy_at_stop), 32'd0);
      chk("vec_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("vec_frm_err", 32'(frm_cnt - f0), 32'(vecs[i].exp_frm));
      pc = vecs[i].exp_cmd;
      pd = vecs[i].exp_data;
      tick(8);
    end

    // Consumer acknowledge
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("clr_keeps_cmd", 32'(cmd), 32'hFF);
    tick(8);

    // Acknowledge held across frame completion: completion must still be seen
    send_byte(8'h11, 1'b1, 10);
    tick(4);
    send_byte(8'h22, 1'b1, 10);
    tick(4);
    send_byte(8'h33, 1'b1, 9);
    clr_cmd_rdy = 1'b1;
    saw_high = 1'b0;
    for (int n = 0; n < BD + 8; n++) begin
      if (cmd_rdy) saw_high = 1'b1;
      tick(1);
    end
    clr_cmd_rdy = 1'b0;
    chk("set_wins_seen", 32'(saw_high), 32'd1);
    chk("set_wins_then_clr", 32'(cmd_rdy), 32'd0);
    chk("set_wins_cmd", 32'(cmd), 32'h11);
    chk("set_wins_data", 32'(data), 32'h2233);
    tick(8);

    tx_check(8'hA5, 1'b1);
    tick(5);

    // Reset during RX byte 3 and a TX data bit
    send_byte(8'h41, 1'b1, 10);
    tick(4);
    send_byte(8'h42, 1'b1, 10);
    tick(2);
    resp = 8'hC3;
    snd_resp = 1'b1;
    tick(1);
    snd_resp = 1'b0;
    send_byte(8'h43, 1'b1, 5);
    chk("pre_reset_tx_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_TX", 32'(TX), 32'd1);
    chk("mid_rst_cmd", 32'(cmd), 32'h00);
    chk("mid_rst_data", 32'(data), 32'h0000);
    chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("mid_rst_resp_sent", 32'(resp_sent), 32'd0);
    chk("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_frm_err", 32'(frm_err), 32'd0);
    rs0 = rs_cnt;
    r0 = rdy_rise;
    rst_n = 1'b1;
    tick(400);
    chk("post_rst_no_resp_sent", 32'(rs_cnt - rs0), 32'd0);
    chk("post_rst_no_cmd_rdy", 32'(rdy_rise - r0), 32'd0);
    chk("post_rst_cmd", 32'(cmd), 32'h00);

    // Randomized full-duplex traffic against a byte-queue frame model
    fork
      begin
        logic [7:0] q[$];
        logic [7:0] exp_cmd, b;
        logic [15:0] exp_data;
        logic exp_rdy, bad, long_gap, was_empty;
        int fs;
        exp_cmd = 8'h00; exp_data = 16'h0000; exp_rdy = 1'b0;
        for (int k = 0; k < 14; k++) begin
          b = 8'($urandom);
          bad = ($urandom_range(0, 5) == 0);
          long_gap = ($urandom_range(0, 5) == 0);
          was_empty = (q.size() == 0);
          fs = frm_cnt;
          send_byte(b, !bad, 10);
          if (was_empty) exp_rdy = 1'b0;
          if (bad) begin
            q.delete();
          end else begin
            q.push_back(b);
            if (q.size() == 3) begin
              exp_cmd = q[0];
              exp_data = {q[1], q[2]};
              exp_rdy = 1'b1;
              q.delete();
            end
          end
          chk("rnd_cmd", 32'(cmd), 32'(exp_cmd));
          chk("rnd_data", 32'(data), 32'(exp_data));
          chk("rnd_cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy));
          chk("rnd_frm_err", 32'(frm_cnt - fs), 32'(bad));
          if (long_gap) begin
            tick(600);
            q.delete();
          end else begin
            tick($urandom_range(4, 40));
          end
        end
      end
      begin
        for (int t = 0; t < 4; t++) begin
          tx_check(8'($urandom), 1'b0);
          tick($urandom_range(0, 30));
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
